// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and event indices for the performance monitor
package perf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DUMP,
        DONE
    } perf_state_e;

    localparam int EV_CYCLE  = 0;
    localparam int EV_RETIRE = 1;
    localparam int EV_STALL  = 2;
    localparam int EV_FLUSH  = 3;
    localparam int EV_BRANCH = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with overflow-attempt pulse
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             ovf_pulse
);

    logic at_max;

    assign at_max    = &count;
    assign ovf_pulse = enable && at_max && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - cycle/event counters with drain window and valid/ready dump
module perf_monitor
    import perf_pkg::*;
#(
    parameter int  NUM_EVENTS   = 4,
    parameter int  CNT_W        = 32,
    parameter int  DRAIN_CYCLES = 5,
    localparam int IDX_W        = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  end_program,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [CNT_W-1:0]      dump_data,
    output logic [IDX_W-1:0]      dump_idx,
    output logic                  dump_last,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_EVENTS:0]   ovf
);

    localparam int NUM_CNT = NUM_EVENTS + 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS);

    perf_state_e        state, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_hit;
    logic [CNT_W-1:0]   dump_word;
    logic               count_en;

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        logic en;
        if (k == EV_CYCLE) begin : g_cycle
            assign en = count_en;
        end else begin : g_event
            assign en = count_en && event_in[k-1];
        end
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .enable    (en),
            .count     (cnt[k]),
            .ovf_pulse (ovf_hit[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (end_program) state_nxt = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
                DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DUMP;
                DUMP:    if (dump_ready && dump_idx == LAST_IDX) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        count_en   = 1'b0;
        dump_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            RUN, DRAIN: begin
                count_en = 1'b1;
                busy     = 1'b1;
            end
            DUMP: begin
                dump_valid = 1'b1;
                busy       = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // drain_cnt counts DRAIN cycles already spent; it idles at zero elsewhere
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (clear || state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dump_idx <= '0;
        end else if (clear) begin
            dump_idx <= '0;
        end else if (dump_valid && dump_ready && !dump_last) begin
            dump_idx <= dump_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= '0;
        end else if (clear) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | ovf_hit;
        end
    end

    // Index compare instead of direct array select keeps out-of-range addresses at zero
    always_comb begin
        rd_data   = '0;
        dump_word = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_addr == IDX_W'(k)) rd_data = cnt[k];
            if (dump_idx == IDX_W'(k)) dump_word = cnt[k];
        end
    end

    assign dump_data = dump_valid ? dump_word : '0;
    assign dump_last = dump_valid && (dump_idx == LAST_IDX);

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - directed self-checking bench for perf_monitor
module tb_perf_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] event_in = '0;
    logic [2:0] rd_addr = '0;
    logic       dump_ready = 1'b0;
    logic [2:0] start_v = '0;
    logic [2:0] end_v = '0;

    logic [31:0] rd_data_a, dump_data_a;
    logic [2:0]  dump_idx_a;
    logic        dump_valid_a, dump_last_a, busy_a, done_a;
    logic [4:0]  ovf_a;

    logic [3:0]  rd_data_b, dump_data_b;
    logic [2:0]  dump_idx_b;
    logic        dump_valid_b, dump_last_b, busy_b, done_b;
    logic [4:0]  ovf_b;

    logic [31:0] rd_data_c, dump_data_c;
    logic [2:0]  dump_idx_c;
    logic        dump_valid_c, dump_last_c, busy_c, done_c;
    logic [4:0]  ovf_c;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] exp1 [5] = '{32'd15, 32'd15, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp2 [5] = '{32'd15, 32'd0, 32'd15, 32'd0, 32'd15};

    always #5 clk = ~clk;

    perf_monitor u_dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .clear(clear),
        .end_program(end_v[0]), .event_in(event_in), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .dump_valid(dump_valid_a), .dump_ready(dump_ready),
        .dump_data(dump_data_a), .dump_idx(dump_idx_a), .dump_last(dump_last_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a)
    );

    perf_monitor #(.CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .clear(clear),
        .end_program(end_v[1]), .event_in(event_in), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .dump_valid(dump_valid_b), .dump_ready(dump_ready),
        .dump_data(dump_data_b), .dump_idx(dump_idx_b), .dump_last(dump_last_b),
        .busy(busy_b), .done(done_b), .ovf(ovf_b)
    );

    perf_monitor #(.DRAIN_CYCLES(0)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .clear(clear),
        .end_program(end_v[2]), .event_in(event_in), .rd_addr(rd_addr),
        .rd_data(rd_data_c), .dump_valid(dump_valid_c), .dump_ready(dump_ready),
        .dump_data(dump_data_c), .dump_idx(dump_idx_c), .dump_last(dump_last_c),
        .busy(busy_c), .done(done_c), .ovf(ovf_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input int which, input int n);
        start_v[which] = 1'b1;
        tick();
        start_v[which] = 1'b0;
        for (int i = 1; i <= n; i++) begin
            end_v[which] = (i == n);
            tick();
        end
        end_v[which] = 1'b0;
    endtask

    task automatic wait_dump_a(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!dump_valid_a && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, n, exp_cycles);
    endtask

    task automatic read_a(input int addr, input string tag, input logic [31:0] exp);
        rd_addr = addr[2:0];
        #1;
        check_eq(tag, rd_data_a, exp);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int xfers;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", dump_valid_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_idx", dump_idx_a, 0);
        check_eq("rst_data", dump_data_a, 0);
        check_eq("rst_last", dump_last_a, 0);
        check_eq("rst_ovf", ovf_a, 0);
        reset = 1'b0;
        tick();

        // 1: basic run, ready always high
        event_in = 4'b0001;
        dump_ready = 1'b1;
        run_prog(0, 10);
        read_a(0, "t1_cnt0_at_end", 10);
        check_eq("t1_busy_drain", busy_a, 1);
        wait_dump_a("t1_drain_len", 5);
        for (int k = 0; k < 5; k++) begin
            check_eq("t1_valid", dump_valid_a, 1);
            check_eq("t1_idx", dump_idx_a, k);
            check_eq("t1_data", dump_data_a, exp1[k]);
            check_eq("t1_last", dump_last_a, (k == 4));
            tick();
        end
        check_eq("t1_done", done_a, 1);
        check_eq("t1_valid_after", dump_valid_a, 0);
        check_eq("t1_busy_after", busy_a, 0);
        start_v[0] = 1'b1;
        end_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        end_v[0] = 1'b0;
        tick();
        check_eq("t1_done_hold", done_a, 1);
        read_a(0, "t1_frozen_cnt0", 15);
        read_a(1, "t1_frozen_cnt1", 15);

        // 2: backpressure, ready pattern 0,0,1 per word
        do_clear();
        check_eq("t2_clr_done", done_a, 0);
        read_a(0, "t2_clr_cnt0", 0);
        event_in = 4'b1010;
        dump_ready = 1'b0;
        run_prog(0, 10);
        wait_dump_a("t2_drain_len", 5);
        xfers = 0;
        for (int k = 0; k < 5; k++) begin
            for (int ph = 0; ph < 3; ph++) begin
                dump_ready = (ph == 2);
                #1;
                check_eq("t2_valid", dump_valid_a, 1);
                check_eq("t2_idx", dump_idx_a, k);
                check_eq("t2_data", dump_data_a, exp2[k]);
                check_eq("t2_last", dump_last_a, (k == 4));
                if (dump_valid_a && dump_ready) xfers++;
                tick();
            end
        end
        check_eq("t2_xfers", xfers, 5);
        check_eq("t2_done", done_a, 1);

        // 3: 4-bit counters saturate
        do_clear();
        dump_ready = 1'b1;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            event_in = (i <= 3) ? 4'b0100 : 4'b0000;
            end_v[1] = (i == 20);
            tick();
        end
        end_v[1] = 1'b0;
        rd_addr = 3'd0;
        #1;
        check_eq("t3_cnt0_sat", rd_data_b, 15);
        rd_addr = 3'd3;
        #1;
        check_eq("t3_cnt3", rd_data_b, 3);
        check_eq("t3_ovf", ovf_b, 5'b00001);
        check_eq("t3_ovf_a_clean", ovf_a, 0);

        // 4: no drain window
        do_clear();
        event_in = 4'b0000;
        dump_ready = 1'b0;
        run_prog(2, 3);
        check_eq("t4_valid", dump_valid_c, 1);
        check_eq("t4_idx", dump_idx_c, 0);
        check_eq("t4_data", dump_data_c, 3);
        check_eq("t4_last", dump_last_c, 0);

        // 5: clear together with start mid-DRAIN
        do_clear();
        event_in = 4'b1111;
        run_prog(0, 4);
        tick();
        tick();
        check_eq("t5_busy_pre", busy_a, 1);
        read_a(2, "t5_cnt2_pre", 6);
        read_a(5, "t5_oob_addr", 0);
        clear = 1'b1;
        start_v[0] = 1'b1;
        tick();
        clear = 1'b0;
        start_v[0] = 1'b0;
        check_eq("t5_busy", busy_a, 0);
        check_eq("t5_done", done_a, 0);
        check_eq("t5_valid", dump_valid_a, 0);
        for (int k = 0; k < 5; k++) read_a(k, "t5_rd_zero", 0);
        tick();
        check_eq("t5_stay_idle", busy_a, 0);
        read_a(0, "t5_no_count", 0);

        // 6: async reset mid-DUMP, end_program in IDLE
        event_in = 4'b0001;
        dump_ready = 1'b0;
        run_prog(0, 2);
        wait_dump_a("t6_drain_len", 5);
        check_eq("t6_valid_pre", dump_valid_a, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_valid_async", dump_valid_a, 0);
        check_eq("t6_busy_async", busy_a, 0);
        #2;
        reset = 1'b0;
        tick();
        end_v[0] = 1'b1;
        tick();
        tick();
        end_v[0] = 1'b0;
        check_eq("t6_idle_busy", busy_a, 0);
        read_a(0, "t6_idle_cnt0", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
